pocket_arcade_inputs: RTL and testbench

Downstream consumer of the Pocket gamepad synchroniser: takes the 16-bit pad vector already in the core clock domain and turns it into clean arcade cabinet controls. Per-button debounce, 4-way joystick resolution, fixed-width coin pulse, start buttons and optional autofire. Outputs feed the arcade core's input ports directly.

---
 rtl/pocket_arcade_inputs.sv | 144 ++++++++++++++
 tb/tb_pocket_arcade_inputs.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pocket_arcade_inputs.sv
// Pad vector to arcade cabinet controls: per-button debounce, 4-way joystick, coin pulse, starts, fire.
// Define AUTOFIRE_EN to add autofire on B; without it B acts as a plain second fire button.
module pocket_arcade_inputs #(
  parameter logic [15:0] DB_LIMIT    = 16'd48000,
  parameter logic [23:0] COIN_CYCLES = 24'd4800000,
  parameter logic [23:0] AF_HALF     = 24'd2400000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [15:0] iPAD,
  output logic [15:0] oDB,
  output logic [3:0]  oDIR,
  output logic        oFIRE,
  output logic        oCOIN,
  output logic        oSTART1,
  output logic        oSTART2
);

  logic [15:0] db;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_debounce
      logic        bit_reg;
      logic [15:0] cnt_reg;

      // Any cycle that agrees with the accepted state restarts the hold count.
      always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
          bit_reg <= 1'b0;
          cnt_reg <= 16'd0;
        end else if (iPAD[gi] == bit_reg) begin
          cnt_reg <= 16'd0;
        end else if (cnt_reg == DB_LIMIT - 16'd1) begin
          bit_reg <= iPAD[gi];
          cnt_reg <= 16'd0;
        end else begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end

      assign db[gi] = bit_reg;
    end
  endgenerate

  assign oDB = db;

  logic [3:0]  dir_reg, dir_next;
  logic        se_prev_reg;
  logic [23:0] coin_cnt_reg, coin_cnt_next;
  logic        start1_reg, start2_reg;
  logic        fire_reg, fire_next;

  // Multiple directions: the current one wins while still held, else fixed priority.
  always_comb begin
    dir_next = 4'b0000;
    case (db[3:0])
      4'b0000: dir_next = 4'b0000;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: dir_next = db[3:0];
      default: begin
        if ((dir_reg & db[3:0]) != 4'b0000) dir_next = dir_reg;
        else if (db[0])                     dir_next = 4'b0001;
        else if (db[1])                     dir_next = 4'b0010;
        else if (db[2])                     dir_next = 4'b0100;
        else                                dir_next = 4'b1000;
      end
    endcase
  end

  always_comb begin
    coin_cnt_next = coin_cnt_reg;
    if (coin_cnt_reg != 24'd0)
      coin_cnt_next = coin_cnt_reg - 24'd1;
    else if (db[14] && !se_prev_reg)
      coin_cnt_next = COIN_CYCLES;
  end

`ifdef AUTOFIRE_EN
  logic        b_prev_reg;
  logic        phase_reg, phase_next;
  logic [23:0] af_cnt_reg, af_cnt_next;

  // Fire uses the next phase so the first high phase starts right after B is accepted.
  always_comb begin
    phase_next  = phase_reg;
    af_cnt_next = af_cnt_reg;
    if (!db[5]) begin
      phase_next  = 1'b0;
      af_cnt_next = 24'd0;
    end else if (!b_prev_reg) begin
      phase_next  = 1'b1;
      af_cnt_next = 24'd0;
    end else if (af_cnt_reg == AF_HALF - 24'd1) begin
      phase_next  = ~phase_reg;
      af_cnt_next = 24'd0;
    end else begin
      af_cnt_next = af_cnt_reg + 24'd1;
    end
    fire_next = db[4] | (db[5] & phase_next);
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      b_prev_reg <= 1'b0;
      phase_reg  <= 1'b0;
      af_cnt_reg <= 24'd0;
    end else begin
      b_prev_reg <= db[5];
      phase_reg  <= phase_next;
      af_cnt_reg <= af_cnt_next;
    end
  end
`else
  // AF_HALF only matters when autofire is built in.
  logic af_half_unused;
  assign af_half_unused = ^AF_HALF;
  assign fire_next = db[4] | db[5];
`endif

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      dir_reg      <= 4'b0000;
      se_prev_reg  <= 1'b0;
      coin_cnt_reg <= 24'd0;
      start1_reg   <= 1'b0;
      start2_reg   <= 1'b0;
      fire_reg     <= 1'b0;
    end else begin
      dir_reg      <= dir_next;
      se_prev_reg  <= db[14];
      coin_cnt_reg <= coin_cnt_next;
      start1_reg   <= db[15];
      start2_reg   <= db[9];
      fire_reg     <= fire_next;
    end
  end

  assign oDIR    = dir_reg;
  assign oCOIN   = (coin_cnt_reg != 24'd0);
  assign oSTART1 = start1_reg;
  assign oSTART2 = start2_reg;
  assign oFIRE   = fire_reg;

endmodule

// File: tb/tb_pocket_arcade_inputs.sv
// Directed bench for pocket_arcade_inputs with DB_LIMIT=4, COIN_CYCLES=8, AF_HALF=3.
// Autofire expectations follow AUTOFIRE_EN when it is defined for the build.
module tb_pocket_arcade_inputs;

  localparam logic [15:0] P_U  = 16'h0001;
  localparam logic [15:0] P_D  = 16'h0002;
  localparam logic [15:0] P_L  = 16'h0004;
  localparam logic [15:0] P_R  = 16'h0008;
  localparam logic [15:0] P_A  = 16'h0010;
  localparam logic [15:0] P_B  = 16'h0020;
  localparam logic [15:0] P_R1 = 16'h0200;
  localparam logic [15:0] P_SE = 16'h4000;
  localparam logic [15:0] P_ST = 16'h8000;
  localparam int AF = 3;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic [15:0] iPAD = 16'h0000;
  logic [15:0] oDB;
  logic [3:0]  oDIR;
  logic        oFIRE, oCOIN, oSTART1, oSTART2;

  int checks = 0;
  int passes = 0;

  pocket_arcade_inputs #(
    .DB_LIMIT(16'd4), .COIN_CYCLES(24'd8), .AF_HALF(24'd3)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iPAD(iPAD), .oDB(oDB), .oDIR(oDIR),
    .oFIRE(oFIRE), .oCOIN(oCOIN), .oSTART1(oSTART1), .oSTART2(oSTART2)
  );

  always #5 iCLK = ~iCLK;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic settle();
    iPAD = 16'h0000;
    tick(12);
  endtask

  task automatic test_reset();
    iRST_N = 1'b0;
    iPAD = 16'hFFFF;
    tick(3);
    checks++; if (oDB !== 16'h0000) $display("FAIL reset_db: got %h want 0000", oDB); else passes++;
    checks++; if (oDIR !== 4'b0000) $display("FAIL reset_dir: got %b want 0000", oDIR); else passes++;
    checks++; if (oFIRE !== 1'b0) $display("FAIL reset_fire: got %b want 0", oFIRE); else passes++;
    checks++; if (oCOIN !== 1'b0) $display("FAIL reset_coin: got %b want 0", oCOIN); else passes++;
    checks++; if ({oSTART1, oSTART2} !== 2'b00) $display("FAIL reset_start: got %b want 00", {oSTART1, oSTART2}); else passes++;
    iPAD = 16'h0000;
    iRST_N = 1'b1;
    tick(2);
    checks++; if (oDB !== 16'h0000) $display("FAIL reset_release_db: got %h want 0000", oDB); else passes++;
    $display("test_reset: done");
  endtask

  task automatic test_glitch();
    iPAD = P_A;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      checks++; if (oDB[4] !== 1'b0) $display("FAIL glitch_db_t%0d: got %b want 0", i, oDB[4]); else passes++;
    end
    iPAD = 16'h0000;
    tick(3);
    checks++; if ({oDB[4], oFIRE} !== 2'b00) $display("FAIL glitch_after: got %b want 00", {oDB[4], oFIRE}); else passes++;
    iPAD = P_A;
    tick(3);
    checks++; if (oDB[4] !== 1'b0) $display("FAIL press_db_t3: got %b want 0", oDB[4]); else passes++;
    tick(1);
    checks++; if (oDB[4] !== 1'b1) $display("FAIL press_db_t4: got %b want 1", oDB[4]); else passes++;
    checks++; if (oFIRE !== 1'b0) $display("FAIL press_fire_t4: got %b want 0", oFIRE); else passes++;
    tick(1);
    checks++; if (oFIRE !== 1'b1) $display("FAIL press_fire_t5: got %b want 1", oFIRE); else passes++;
    settle();
    checks++; if ({oDB[4], oFIRE} !== 2'b00) $display("FAIL release_fire: got %b want 00", {oDB[4], oFIRE}); else passes++;
    $display("test_glitch: done");
  endtask

  task automatic test_coin();
    int first_hi, hi, rises;
    logic prev;
    // SE held long: one pulse only
    iPAD = P_SE; first_hi = -1; hi = 0; rises = 0; prev = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (oCOIN) begin hi++; if (first_hi < 0) first_hi = i; end
      if (oCOIN && !prev) rises++;
      prev = oCOIN;
    end
    checks++; if (first_hi != 5) $display("FAIL coin_hold_start: got %0d want 5", first_hi); else passes++;
    checks++; if (hi != 8) $display("FAIL coin_hold_width: got %0d want 8", hi); else passes++;
    checks++; if (rises != 1) $display("FAIL coin_hold_pulses: got %0d want 1", rises); else passes++;
    iPAD = 16'h0000;
    tick(8);
    iPAD = P_SE; first_hi = -1; hi = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (oCOIN) begin hi++; if (first_hi < 0) first_hi = i; end
    end
    checks++; if (first_hi != 5) $display("FAIL coin_repress_start: got %0d want 5", first_hi); else passes++;
    checks++; if (hi != 8) $display("FAIL coin_repress_width: got %0d want 8", hi); else passes++;
    settle();
    // release and re-press while the pulse is still running
    first_hi = -1; hi = 0; rises = 0; prev = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      iPAD = (i <= 4 || i >= 9) ? P_SE : 16'h0000;
      tick(1);
      if (oCOIN) begin hi++; if (first_hi < 0) first_hi = i; end
      if (oCOIN && !prev) rises++;
      prev = oCOIN;
    end
    checks++; if (hi != 8) $display("FAIL coin_mid_width: got %0d want 8", hi); else passes++;
    checks++; if (rises != 1) $display("FAIL coin_mid_pulses: got %0d want 1", rises); else passes++;
    settle();
    $display("test_coin: done");
  endtask

  task automatic test_dir();
    iPAD = P_U;
    tick(4);
    checks++; if (oDIR !== 4'b0000) $display("FAIL dir_u_latency: got %b want 0000", oDIR); else passes++;
    tick(1);
    checks++; if (oDIR !== 4'b0001) $display("FAIL dir_u: got %b want 0001", oDIR); else passes++;
    iPAD = P_U | P_R;
    tick(6);
    checks++; if (oDIR !== 4'b0001) $display("FAIL dir_u_r_hold: got %b want 0001", oDIR); else passes++;
    iPAD = P_R;
    tick(5);
    checks++; if (oDIR !== 4'b1000) $display("FAIL dir_r_after_u: got %b want 1000", oDIR); else passes++;
    iPAD = 16'h0000;
    tick(5);
    checks++; if (oDIR !== 4'b0000) $display("FAIL dir_idle: got %b want 0000", oDIR); else passes++;
    iPAD = P_L | P_D;
    tick(5);
    checks++; if (oDIR !== 4'b0010) $display("FAIL dir_l_d: got %b want 0010", oDIR); else passes++;
    iPAD = P_L;
    tick(5);
    checks++; if (oDIR !== 4'b0100) $display("FAIL dir_l_after_d: got %b want 0100", oDIR); else passes++;
    iPAD = P_L | P_R;
    tick(6);
    checks++; if (oDIR !== 4'b0100) $display("FAIL dir_l_r_hold: got %b want 0100", oDIR); else passes++;
    settle();
    $display("test_dir: done");
  endtask

  task automatic test_autofire();
    logic exp;
    iPAD = P_B;
    tick(4);
    checks++; if (oDB[5] !== 1'b1) $display("FAIL af_db: got %b want 1", oDB[5]); else passes++;
    for (int j = 0; j < 20; j++) begin
      tick(1);
`ifdef AUTOFIRE_EN
      exp = ((j / AF) % 2 == 0);
`else
      exp = 1'b1;
`endif
      checks++; if (oFIRE !== exp) $display("FAIL af_b_cycle%0d: got %b want %b", j, oFIRE, exp); else passes++;
    end
    iPAD = 16'h0000;
    tick(6);
    checks++; if (oFIRE !== 1'b0) $display("FAIL af_release: got %b want 0", oFIRE); else passes++;
    iPAD = P_A | P_B;
    tick(4);
    for (int j = 0; j < 12; j++) begin
      tick(1);
      checks++; if (oFIRE !== 1'b1) $display("FAIL af_ab_cycle%0d: got %b want 1", j, oFIRE); else passes++;
    end
    settle();
    $display("test_autofire: done");
  endtask

  task automatic test_starts();
    iPAD = P_ST;
    tick(4);
    checks++; if ({oDB[15], oSTART1} !== 2'b10) $display("FAIL start1_latency: got %b want 10", {oDB[15], oSTART1}); else passes++;
    tick(1);
    checks++; if (oSTART1 !== 1'b1) $display("FAIL start1: got %b want 1", oSTART1); else passes++;
    iPAD = P_ST | P_R1;
    tick(4);
    checks++; if ({oDB[9], oSTART2} !== 2'b10) $display("FAIL start2_latency: got %b want 10", {oDB[9], oSTART2}); else passes++;
    tick(1);
    checks++; if ({oSTART1, oSTART2} !== 2'b11) $display("FAIL start_both: got %b want 11", {oSTART1, oSTART2}); else passes++;
    settle();
    checks++; if ({oSTART1, oSTART2} !== 2'b00) $display("FAIL start_release: got %b want 00", {oSTART1, oSTART2}); else passes++;
    iPAD = P_ST | P_R1;
    tick(1);
    iPAD = 16'h0000;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      checks++; if ({oSTART1, oSTART2, oDB[15], oDB[9]} !== 4'b0000) $display("FAIL start_spike_t%0d: got %b want 0000", i, {oSTART1, oSTART2, oDB[15], oDB[9]}); else passes++;
    end
    $display("test_starts: done");
  endtask

  task automatic test_reset_mid_pulse();
    int first_hi, hi;
    iPAD = P_SE | P_A | P_ST | P_U;
    tick(7);
    checks++; if ({oCOIN, oFIRE, oSTART1} !== 3'b111) $display("FAIL rmp_before: got %b want 111", {oCOIN, oFIRE, oSTART1}); else passes++;
    checks++; if (oDIR !== 4'b0001) $display("FAIL rmp_before_dir: got %b want 0001", oDIR); else passes++;
    iRST_N = 1'b0;
    tick(1);
    checks++; if (oCOIN !== 1'b0) $display("FAIL rmp_coin: got %b want 0", oCOIN); else passes++;
    checks++; if (oDB !== 16'h0000) $display("FAIL rmp_db: got %h want 0000", oDB); else passes++;
    checks++; if ({oDIR, oFIRE, oSTART1, oSTART2} !== 7'd0) $display("FAIL rmp_outs: got %b want 0000000", {oDIR, oFIRE, oSTART1, oSTART2}); else passes++;
    tick(1);
    iPAD = P_SE;
    iRST_N = 1'b1;
    first_hi = -1; hi = 0;
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      if (oCOIN) begin hi++; if (first_hi < 0) first_hi = i; end
    end
    checks++; if (first_hi != 5) $display("FAIL rmp_new_start: got %0d want 5", first_hi); else passes++;
    checks++; if (hi != 8) $display("FAIL rmp_new_width: got %0d want 8", hi); else passes++;
    settle();
    $display("test_reset_mid_pulse: done");
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_coin();
    test_dir();
    test_autofire();
    test_starts();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
